// File: rtl/imem_loader.sv
// Byte-stream program loader feeding a 256-byte instruction memory, with
// a wrapping big-endian fetch port, a load checksum and a sticky misaligned-fetch flag.
module imem_loader #(
  parameter int DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        run,
  output logic [31:0] checksum,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  ptr_q;
  logic [8:0]  cnt_q;
  logic [8:0]  total_q;
  logic [23:0] asm_q;
  logic [31:0] checksum_q;
  logic        misalign_q;
  logic        run_q;
  logic        ready_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        xfer;
  logic [31:0] word_d;
  logic [8:0]  cnt_d;
  logic [7:0]  a0, a1, a2, a3;
  logic        unused_addr_hi;

  // Reset outranks any transfer, so the aborted cycle never writes memory.
  assign xfer   = ready_q & byte_valid & ~rst;
  assign word_d = {asm_q, byte_data};
  assign cnt_d  = cnt_q + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 8'd0;
      cnt_q      <= 9'd0;
      total_q    <= 9'd0;
      asm_q      <= 24'd0;
      checksum_q <= 32'd0;
      misalign_q <= 1'b0;
      run_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            ptr_q      <= 8'd0;
            cnt_q      <= 9'd0;
            asm_q      <= 24'd0;
            checksum_q <= 32'd0;
            misalign_q <= 1'b0;
            total_q    <= {word_count, 2'b00};
            if (word_count == 7'd0) begin
              state_q <= S_DONE;
              run_q   <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q <= S_LOAD;
              run_q   <= 1'b0;
              ready_q <= 1'b1;
            end
          end else if (run_q && (fetch_addr[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            ptr_q <= ptr_q + 8'd1;
            cnt_q <= cnt_d;
            asm_q <= word_d[23:0];
            if (cnt_q[1:0] == 2'b11) begin
              checksum_q <= checksum_q ^ word_d;
            end
            if (cnt_d == total_q) begin
              state_q <= S_DONE;
              run_q   <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory has no reset: an aborted or shorter load leaves older bytes intact.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[ptr_q] <= byte_data;
    end
  end

  assign a0 = fetch_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign unused_addr_hi = ^fetch_addr[31:8];

  assign fetch_instr = run_q ? {mem[a0], mem[a1], mem[a2], mem[a3]} : 32'h0000_0000;
  assign byte_ready  = ready_q;
  assign run         = run_q;
  assign checksum    = checksum_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs change on the falling edge, outputs are
// checked on the falling edge (or shortly after, for the combinational fetch port).
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        run;
  logic [31:0] checksum;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  imem_loader #(.DEPTH_BYTES(256)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .run(run),
    .checksum(checksum), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered and left at a falling edge.
  task automatic start_load(input logic [6:0] wc);
    start = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    byte_valid = 1'b1;
    byte_data = d;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %0b want 0", run); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", byte_ready); end
    checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL reset_checksum got %h want 0", checksum); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b want 0", misalign); end
    checks++; if (fetch_instr !== 32'h0) begin errors++; $display("FAIL reset_fetch got %h want 0", fetch_instr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_continuous();
    logic [7:0] bytes [8] = '{8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'h22, 8'h20, 8'h22};
    start_load(7'd2);
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL cont_ready got %0b want 1", byte_ready); end
    for (int i = 0; i < 7; i++) send_byte(bytes[i]);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL cont_run_early got %0b want 0", run); end
    send_byte(bytes[7]);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL cont_run got %0b want 1", run); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_done got %0b want 0", byte_ready); end
    checks++; if (checksum !== 32'h0000_3802) begin errors++; $display("FAIL cont_checksum got %h want 00003802", checksum); end
    fetch_addr = 32'd0; #1;
    checks++; if (fetch_instr !== 32'h0022_1820) begin errors++; $display("FAIL cont_fetch0 got %h want 00221820", fetch_instr); end
    fetch_addr = 32'd4; #1;
    checks++; if (fetch_instr !== 32'h0022_2022) begin errors++; $display("FAIL cont_fetch4 got %h want 00222022", fetch_instr); end
    fetch_addr = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_toggle();
    logic [7:0] bytes [8] = '{8'h00, 8'h22, 8'h18, 8'h20, 8'h00, 8'h22, 8'h20, 8'h22};
    start_load(7'd2);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL tog_run_drop got %0b want 0", run); end
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b0;
      byte_data = 8'hEE;
      @(negedge clk);
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL tog_run_early byte %0d got %0b want 0", i, run); end
      send_byte(bytes[i]);
    end
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL tog_run got %0b want 1", run); end
    checks++; if (checksum !== 32'h0000_3802) begin errors++; $display("FAIL tog_checksum got %h want 00003802", checksum); end
    fetch_addr = 32'd0; #1;
    checks++; if (fetch_instr !== 32'h0022_1820) begin errors++; $display("FAIL tog_fetch0 got %h want 00221820", fetch_instr); end
    fetch_addr = 32'd4; #1;
    checks++; if (fetch_instr !== 32'h0022_2022) begin errors++; $display("FAIL tog_fetch4 got %h want 00222022", fetch_instr); end
    fetch_addr = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_start_in_load();
    start_load(7'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    start = 1'b1;
    word_count = 7'd0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL sil_ready got %0b want 1", byte_ready); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL sil_run_early got %0b want 0", run); end
    send_byte(8'h03);
    send_byte(8'h04);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL sil_run got %0b want 1", run); end
    checks++; if (checksum !== 32'h0102_0304) begin errors++; $display("FAIL sil_checksum got %h want 01020304", checksum); end
    fetch_addr = 32'd0; #1;
    checks++; if (fetch_instr !== 32'h0102_0304) begin errors++; $display("FAIL sil_fetch0 got %h want 01020304", fetch_instr); end
    @(negedge clk);
  endtask

  task automatic test_zero_words();
    start_load(7'd0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL zero_run got %0b want 1", run); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL zero_ready got %0b want 0", byte_ready); end
    checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL zero_checksum got %h want 0", checksum); end
    fetch_addr = 32'd0; #1;
    checks++; if (fetch_instr !== 32'h0102_0304) begin errors++; $display("FAIL zero_fetch0 got %h want 01020304", fetch_instr); end
    @(negedge clk);
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_cs;
    logic [7:0]  b0;
    exp_cs = 32'h0;
    for (int k = 0; k < 64; k++) begin
      b0 = 8'(4 * k);
      exp_cs = exp_cs ^ {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
    end
    start_load(7'd64);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL full_run got %0b want 1", run); end
    checks++; if (checksum !== exp_cs) begin errors++; $display("FAIL full_checksum got %h want %h", checksum, exp_cs); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL full_misalign_pre got %0b want 0", misalign); end
    fetch_addr = 32'd252; #1;
    checks++; if (fetch_instr !== 32'hFCFD_FEFF) begin errors++; $display("FAIL full_fetch252 got %h want fcfdfeff", fetch_instr); end
    fetch_addr = 32'd254; #1;
    checks++; if (fetch_instr !== 32'hFEFF_0001) begin errors++; $display("FAIL full_fetch254 got %h want feff0001", fetch_instr); end
    @(negedge clk);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL full_misalign got %0b want 1", misalign); end
    fetch_addr = 32'd0;
    @(negedge clk);
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL full_misalign_sticky got %0b want 1", misalign); end
  endtask

  task automatic test_abort_reload();
    start_load(7'd2);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL abort_run_drop got %0b want 0", run); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL abort_misalign_clr got %0b want 0", misalign); end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fetch_addr = 32'd0; #1;
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL abort_run got %0b want 0", run); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %0b want 0", byte_ready); end
    checks++; if (fetch_instr !== 32'h0) begin errors++; $display("FAIL abort_fetch got %h want 0", fetch_instr); end
    @(negedge clk);
    start_load(7'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL reload_run got %0b want 1", run); end
    checks++; if (checksum !== 32'hAABB_CCDD) begin errors++; $display("FAIL reload_checksum got %h want aabbccdd", checksum); end
    fetch_addr = 32'd0; #1;
    checks++; if (fetch_instr !== 32'hAABB_CCDD) begin errors++; $display("FAIL reload_fetch0 got %h want aabbccdd", fetch_instr); end
    fetch_addr = 32'd4; #1;
    checks++; if (fetch_instr !== 32'h5505_0607) begin errors++; $display("FAIL reload_fetch4 got %h want 55050607", fetch_instr); end
    fetch_addr = 32'd0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    word_count = 7'd0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    fetch_addr = 32'd0;
    test_reset();
    test_load_continuous();
    test_toggle();
    test_start_in_load();
    test_zero_words();
    test_full_wrap();
    test_abort_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 256, the instruction-memory size in bytes; 256 is the only supported value.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  begin a program load; sampled in IDLE and DONE only.
REQ-005 SHALL have port word_count  input  7  number of 32-bit words to load (0-64); captured when start is accepted.
REQ-006 SHALL have port byte_valid  input  1  the loader source presents byte_data this cycle.
REQ-007 SHALL have port byte_data  input  8  program byte, big-endian stream order (MSB byte of each word first).
REQ-008 SHALL have port byte_ready  output  1  the loader accepts a byte this cycle.
REQ-009 SHALL have port fetch_addr  input  32  byte address from the fetch unit.
REQ-010 SHALL have port fetch_instr  output  32  instruction word read at fetch_addr.
REQ-011 SHALL have port run  output  1  the program is loaded and fetch may proceed.
REQ-012 SHALL have port checksum  output  32  XOR of all words loaded in the current/last load.
REQ-013 SHALL have port misalign  output  1  sticky flag: a misaligned fetch occurred while run=1.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-015 IDLE/DONE + start=1: if word_count=0 go to DONE with no writes and checksum=0, else go to LOAD; in both cases clear byte pointer, byte counter, word-assembly register, checksum and misalign.
REQ-016 byte_ready SHALL be 1 exactly when the state is LOAD; start SHALL be ignored in LOAD.
REQ-017 Byte transfer SHALL occur when byte_valid & byte_ready; byte_data is written to Mem[ptr], ptr increments by 1; no transfer means no state change.
REQ-018 The assembly register SHALL shift left by 8 and take byte_data on each transfer; on every 4th transfer, checksum <= checksum XOR {assembly[23:0], byte_data}.
REQ-019 The transfer completing byte word_count*4 SHALL move the FSM to DONE; run goes 1 in the next cycle.
REQ-020 run SHALL be 1 in DONE and 0 in IDLE and LOAD.
REQ-021 fetch_instr SHALL be combinational {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]} with a = fetch_addr[7:0] and each byte index taken mod 256 (wrap 255->0), when run=1; it SHALL be 32'h0000_0000 when run=0.
REQ-022 misalign SHALL be set on the rising edge when run=1 and fetch_addr[1:0]!=0; it stays set until rst or an accepted start; the read itself SHALL still return the unaligned bytes.
REQ-023 Bytes in Mem not written by the current load SHALL keep their previous contents.
REQ-024 A byte write and a fetch to the same address in one cycle cannot conflict (fetch is gated by run=0 during LOAD).

Reset
REQ-025 rst=1 SHALL set state=IDLE, run=0, byte_ready=0, checksum=0, misalign=0, and clear ptr, counter and assembly register, taking priority over start and byte transfers.
REQ-026 Reset mid-LOAD SHALL abort the load; bytes already written remain in Mem and are not cleared; Mem is never reset.
REQ-027 After reset fetch_instr SHALL read 32'h0000_0000 until a load completes.

Verification
REQ-028 Load 2 words, bytes 00 22 18 20 00 22 20 22 with byte_valid held high -> 8 transfers over 8 cycles, run=1 one cycle after the 8th, fetch_addr=0 -> 32'h00221820, fetch_addr=4 -> 32'h00222022, checksum=32'h00003802.
REQ-029 Same load with byte_valid toggled every other cycle -> identical Mem contents and checksum; DONE reached one cycle after the 8th accepted byte only.
REQ-030 start with word_count=0 -> DONE next cycle, run=1, no byte_ready, checksum=0.
REQ-031 Load 64 words of pattern byte i = i, then fetch_addr=252 -> 32'hFCFDFEFF; fetch_addr=254 -> 32'hFEFF0001 and misalign=1 the next cycle.
REQ-032 rst asserted after 5 of 8 bytes -> next cycle IDLE, run=0, fetch_instr=0; a new 1-word load of AA BB CC DD -> Mem[0..3] overwritten, Mem[4] keeps the byte from the aborted load, checksum=32'hAABBCCDD.
REQ-033 start asserted during LOAD -> ignored, the load completes normally; start in DONE -> reload begins, run drops to 0 the next cycle, misalign cleared.
